// File: rtl/dff_bank_ctrl.sv
// Sequencer for a bank of async preset/clear flops shared by two requesters.
// Arbitrates round-robin, pulses pre/clr, waits for settle, then checks q against the shadow d.
module dff_bank_ctrl #(
  parameter int unsigned N      = 8,
  parameter int unsigned IDXW   = 3,
  parameter int unsigned PULSE  = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic            i_clk,
  input  logic            i_clr,
  input  logic [1:0]      i_req,
  input  logic [1:0]      i_op0,
  input  logic [IDXW-1:0] i_idx0,
  input  logic            i_dat0,
  input  logic [1:0]      i_op1,
  input  logic [IDXW-1:0] i_idx1,
  input  logic            i_dat1,
  output logic [1:0]      o_ack,
  output logic            o_err,
  output logic            o_busy,
  output logic [N-1:0]    o_ff_d,
  output logic [N-1:0]    o_ff_pre_n,
  output logic [N-1:0]    o_ff_clr_n,
  input  logic [N-1:0]    i_ff_q
);

  typedef enum logic [1:0] {StIdle, StExec, StSettle, StCheck} state_e;

  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpSet   = 2'b01;
  localparam logic [1:0] OpClear = 2'b10;
  localparam logic [1:0] OpRsvd  = 2'b11;

  localparam int unsigned     CntMax     = (PULSE > SETTLE) ? PULSE : SETTLE;
  localparam int unsigned     CntW       = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] PulseLast  = CntW'(PULSE - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);
  localparam logic [IDXW:0]   NumFlops   = (IDXW + 1)'(N);

  state_e          r_state, w_state;
  logic            r_grant, w_grant;
  logic            r_last, w_last;
  logic [1:0]      r_op, w_op;
  logic [IDXW-1:0] r_idx, w_idx;
  logic            r_ill, w_ill;
  logic [CntW-1:0] r_cnt, w_cnt;
  logic [N-1:0]    r_ff_d, w_ff_d;
  logic [N-1:0]    r_pre_n, w_pre_n;
  logic [N-1:0]    r_clr_n, w_clr_n;
  logic [1:0]      r_ack, w_ack;
  logic            r_busy, w_busy;

  logic            w_win;
  logic [1:0]      w_sel_op;
  logic [IDXW-1:0] w_sel_idx;
  logic            w_sel_dat;
  logic            w_sel_ill;

  // On a tie the requester not granted last wins; a lone request always wins.
  assign w_win     = (i_req == 2'b11) ? ~r_last : i_req[1];
  assign w_sel_op  = w_win ? i_op1 : i_op0;
  assign w_sel_idx = w_win ? i_idx1 : i_idx0;
  assign w_sel_dat = w_win ? i_dat1 : i_dat0;
  assign w_sel_ill = (w_sel_op == OpRsvd) || ({1'b0, w_sel_idx} >= NumFlops);

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_last  = r_last;
    w_op    = r_op;
    w_idx   = r_idx;
    w_ill   = r_ill;
    w_cnt   = r_cnt;
    w_ff_d  = r_ff_d;
    w_pre_n = '1;
    w_clr_n = '1;
    w_ack   = 2'b00;
    unique case (r_state)
      StIdle: begin
        if (|i_req) begin
          w_state = StExec;
          w_grant = w_win;
          w_last  = w_win;
          w_op    = w_sel_op;
          w_idx   = w_sel_idx;
          w_ill   = w_sel_ill;
          w_cnt   = '0;
          // Shadow d follows the command so the flop holds its new value once pre/clr release.
          if (!w_sel_ill) begin
            case (w_sel_op)
              OpLoad:  w_ff_d[w_sel_idx] = w_sel_dat;
              OpSet: begin
                w_ff_d[w_sel_idx]  = 1'b1;
                w_pre_n[w_sel_idx] = 1'b0;
              end
              OpClear: begin
                w_ff_d[w_sel_idx]  = 1'b0;
                w_clr_n[w_sel_idx] = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      StExec: begin
        // Illegal commands touch nothing and spend a single dead cycle before CHECK.
        if (r_ill) begin
          w_state        = StCheck;
          w_ack[r_grant] = 1'b1;
        end else if ((r_op == OpLoad) || (r_cnt == PulseLast)) begin
          w_state = StSettle;
          w_cnt   = '0;
        end else begin
          w_cnt   = r_cnt + 1'b1;
          w_pre_n = r_pre_n;
          w_clr_n = r_clr_n;
        end
      end
      StSettle: begin
        if (r_cnt == SettleLast) begin
          w_state        = StCheck;
          w_ack[r_grant] = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      StCheck: w_state = StIdle;
      default: w_state = StIdle;
    endcase
    w_busy = (w_state != StIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= StIdle;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_op    <= OpLoad;
      r_idx   <= '0;
      r_ill   <= 1'b0;
      r_cnt   <= '0;
      r_ff_d  <= '0;
      r_pre_n <= '1;
      r_clr_n <= '0;
      r_ack   <= 2'b00;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_last  <= w_last;
      r_op    <= w_op;
      r_idx   <= w_idx;
      r_ill   <= w_ill;
      r_cnt   <= w_cnt;
      r_ff_d  <= w_ff_d;
      r_pre_n <= w_pre_n;
      r_clr_n <= w_clr_n;
      r_ack   <= w_ack;
      r_busy  <= w_busy;
    end
  end

  assign o_ack      = r_ack;
  assign o_busy     = r_busy;
  assign o_ff_d     = r_ff_d;
  assign o_ff_pre_n = r_pre_n;
  assign o_ff_clr_n = r_clr_n;
  assign o_err      = (r_state == StCheck) && (r_ill || (i_ff_q[r_idx] != r_ff_d[r_idx]));

endmodule
